// File: rtl/bemicro_cv_pb_sw_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button/switch controller.
// Word-addressed, no wait states; readdata is registered in the slave.
interface bemicro_cv_pb_sw_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/bemicro_cv_pb_sw_ctrl.sv
// Push-button/switch controller: 2-flop sync, per-bit debounce, selectable
// edge capture into W1C sticky bits, and a maskable level interrupt.
module bemicro_cv_pb_sw_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    bemicro_cv_pb_sw_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [WIDTH-1:0]            stable;
    logic [WIDTH-1:0]            stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [WIDTH-1:0]            mask;
    logic [WIDTH-1:0]            sel;
    logic [WIDTH-1:0]            cap;
    logic [WIDTH-1:0]            edge_ev;
    logic [WIDTH-1:0]            wdata;
    logic [31:0]                 rd_mux;
    logic                        wr_en;
    logic                        unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = &{1'b0, bus.writedata[31:WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Each bit must differ from stable for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable   <= '0;
            stable_d <= '0;
            cnt      <= '0;
        end else begin
            stable_d <= stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_TC) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign edge_ev = (stable & ~stable_d & sel) | (~stable & stable_d & ~sel);

    // A new event outranks a same-cycle W1C so no edge is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
            sel  <= '0;
            cap  <= '0;
        end else begin
            if (wr_en && bus.address == 2'd1) mask <= wdata;
            if (wr_en && bus.address == 2'd3) sel  <= wdata;
            if (wr_en && bus.address == 2'd2) cap <= (cap & ~wdata) | edge_ev;
            else                              cap <= cap | edge_ev;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0: rd_mux[WIDTH-1:0] = stable;
            2'd1: rd_mux[WIDTH-1:0] = mask;
            2'd2: rd_mux[WIDTH-1:0] = cap;
            2'd3: rd_mux[WIDTH-1:0] = sel;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

    assign irq = |(cap & mask);

endmodule
